// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample packer: FSM encoding, packed-word
// field positions and the default flush timeout.
package adc_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_t;

  localparam int SEQ_HI    = 31;
  localparam int SEQ_LO    = 30;
  localparam int NEW_HI    = 29;
  localparam int NEW_LO    = 16;
  localparam int START_BIT = 15;
  localparam int ODD_BIT   = 14;
  localparam int OLD_HI    = 13;
  localparam int OLD_LO    = 0;

  localparam int DEFAULT_FLUSH_TIMEOUT = 40;

  function automatic logic [31:0] pack_word(input logic [1:0]  seq,
                                            input logic [13:0] newer,
                                            input logic        start,
                                            input logic        odd,
                                            input logic [13:0] older);
    logic [31:0] w;
    w                  = '0;
    w[SEQ_HI:SEQ_LO]   = seq;
    w[NEW_HI:NEW_LO]   = newer;
    w[START_BIT]       = start;
    w[ODD_BIT]         = odd;
    w[OLD_HI:OLD_LO]   = older;
    return w;
  endfunction

endpackage

// File: rtl/adc_pack_queue.sv
// Small synchronous word FIFO between the packer and the host pack FIFO.
// A push into a full queue is accepted when a pop happens in the same cycle.
module adc_pack_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs pairs of 14-bit ADC samples into tagged 32-bit words for the host.
// Optional decimation is enabled by defining ADC_PACK_DECIM_EN.
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int QUEUE_DEPTH   = 4,
  parameter int FLUSH_TIMEOUT = DEFAULT_FLUSH_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_sample_data,
  input  logic        i_sample_we,
  input  logic        i_record,
  input  logic [3:0]  i_decim,
  input  logic        i_drop_clr,
  output logic [31:0] o_pack_fifo_data,
  output logic        o_pack_fifo_we,
  input  logic        i_pack_fifo_full,
  output logic [15:0] o_drop_count,
  output logic        o_busy
);

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(FLUSH_TIMEOUT);

  pack_state_t state, state_next;
  logic          rec_meta, rec_sync, rec_prev, rec_rise;
  logic [13:0]   held;
  logic [1:0]    seq;
  logic          start_armed;
  logic [TW-1:0] timer;
  logic          keep, accept, hold_load;
  logic          push, push_odd, push_ok;
  logic [31:0]   push_word;
  logic [1:0]    drop_amt;
  logic [16:0]   drop_sum;
  logic          q_full, q_empty, q_pop;
  logic [31:0]   q_rdata;
  logic          unused_bits;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_meta <= 1'b0;
      rec_sync <= 1'b0;
      rec_prev <= 1'b0;
    end else begin
      rec_meta <= i_record;
      rec_sync <= rec_meta;
      rec_prev <= rec_sync;
    end
  end

  assign rec_rise = rec_sync & ~rec_prev;

`ifdef ADC_PACK_DECIM_EN
  logic [3:0] decim_cnt;

  assign keep        = (decim_cnt == 4'd0);
  assign unused_bits = ^i_sample_data[15:14];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         decim_cnt <= 4'd0;
    else if (rec_rise)    decim_cnt <= 4'd0;
    else if (i_sample_we) decim_cnt <= keep ? i_decim : decim_cnt - 4'd1;
  end
`else
  assign keep        = 1'b1;
  assign unused_bits = ^{i_sample_data[15:14], i_decim};
`endif

  assign accept = i_sample_we & keep;

  // A held sample is flushed as an odd word on record start so it never
  // pairs with a sample from the new record.
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    push       = 1'b0;
    push_odd   = 1'b0;
    push_word  = '0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          hold_load  = 1'b1;
          state_next = ST_HALF;
        end
      end
      ST_HALF: begin
        if (rec_rise) begin
          push      = 1'b1;
          push_odd  = 1'b1;
          push_word = pack_word(seq, 14'd0, 1'b0, 1'b1, held);
          if (accept) hold_load  = 1'b1;
          else        state_next = ST_EMPTY;
        end else if (accept) begin
          push       = 1'b1;
          push_word  = pack_word(seq, i_sample_data[13:0], start_armed, 1'b0, held);
          state_next = ST_EMPTY;
        end else if (!rec_sync && timer == TIMEOUT_VAL) begin
          push       = 1'b1;
          push_odd   = 1'b1;
          push_word  = pack_word(seq, 14'd0, start_armed, 1'b1, held);
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  assign q_pop    = ~q_empty & ~i_pack_fifo_full;
  assign push_ok  = push & (~q_full | q_pop);
  assign drop_amt = (push & ~push_ok) ? (push_odd ? 2'd1 : 2'd2) : 2'd0;
  assign drop_sum = {1'b0, o_drop_count} + {15'd0, drop_amt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_EMPTY;
      held        <= '0;
      seq         <= '0;
      start_armed <= 1'b1;
      timer       <= '0;
    end else begin
      state <= state_next;
      if (hold_load) held <= i_sample_data[13:0];
      if (rec_rise)  seq <= 2'd0;
      else if (push) seq <= seq + 2'd1;
      if (rec_rise)  start_armed <= 1'b1;
      else if (push) start_armed <= 1'b0;
      if (state != ST_HALF || rec_sync)
        timer <= '0;
      else if (state_next == ST_HALF && timer != TIMEOUT_VAL)
        timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_drop_count <= 16'd0;
    else if (i_drop_clr)
      o_drop_count <= {14'd0, drop_amt};
    else if (drop_amt != 2'd0)
      o_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  adc_pack_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .push (push),
    .pop  (q_pop),
    .wdata(push_word),
    .rdata(q_rdata),
    .full (q_full),
    .empty(q_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pack_fifo_data <= '0;
      o_pack_fifo_we   <= 1'b0;
    end else begin
      o_pack_fifo_we <= q_pop;
      if (q_pop) o_pack_fifo_data <= q_rdata;
    end
  end

  assign o_busy = (state == ST_HALF) | ~q_empty;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed self-checking bench for adc_sample_packer (QUEUE_DEPTH=4).
// The decimation case runs only when ADC_PACK_DECIM_EN is defined.
module tb_adc_sample_packer;

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] i_sample_data;
  logic        i_sample_we;
  logic        i_record;
  logic [3:0]  i_decim;
  logic        i_drop_clr;
  logic [31:0] o_pack_fifo_data;
  logic        o_pack_fifo_we;
  logic        i_pack_fifo_full;
  logic [15:0] o_drop_count;
  logic        o_busy;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle        = 0;
  int wbase        = 0;
  logic [31:0] wq[$];
  int          wstamp[$];

  adc_sample_packer #(
    .QUEUE_DEPTH  (4),
    .FLUSH_TIMEOUT(40)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_sample_data   (i_sample_data),
    .i_sample_we     (i_sample_we),
    .i_record        (i_record),
    .i_decim         (i_decim),
    .i_drop_clr      (i_drop_clr),
    .o_pack_fifo_data(o_pack_fifo_data),
    .o_pack_fifo_we  (o_pack_fifo_we),
    .i_pack_fifo_full(i_pack_fifo_full),
    .o_drop_count    (o_drop_count),
    .o_busy          (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Host-side capture of every pack FIFO write, stamped with its cycle.
  always @(negedge i_clk) begin
    cycle <= cycle + 1;
    if (o_pack_fifo_we) begin
      wq.push_back(o_pack_fifo_data);
      wstamp.push_back(cycle);
    end
  end

  function automatic logic [31:0] mkWord(input logic [1:0] s, input logic [13:0] nw,
                                         input logic st, input logic od,
                                         input logic [13:0] old);
    return {s, nw, st, od, old};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d);
    i_sample_data = d;
    i_sample_we   = 1'b1;
    tick(1);
    i_sample_we   = 1'b0;
  endtask

  task automatic doReset();
    i_rst_n          = 1'b0;
    i_sample_data    = '0;
    i_sample_we      = 1'b0;
    i_record         = 1'b0;
    i_decim          = 4'd0;
    i_drop_clr       = 1'b0;
    i_pack_fifo_full = 1'b0;
    tick(3);
    i_rst_n = 1'b1;
    tick(1);
    wbase = wq.size();
  endtask

  task automatic waitWrites(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (wq.size() - wbase >= n) break;
      tick(1);
    end
    tick(2);
  endtask

  task automatic startRecord();
    i_record = 1'b1;
    tick(4);
  endtask

  initial begin
    $display("[TB] start");

    // Reset state and a single start-of-record pair with exact latency.
    doReset();
    checkOutput("rst_data", o_pack_fifo_data, 32'h0);
    checkOutput("rst_we", {31'd0, o_pack_fifo_we}, 32'd0);
    checkOutput("rst_drop", {16'd0, o_drop_count}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    startRecord();
    applyStimulus(16'h0011);
    checkOutput("half_busy", {31'd0, o_busy}, 32'd1);
    applyStimulus(16'hC022);
    checkOutput("we_t1", {31'd0, o_pack_fifo_we}, 32'd0);
    tick(1);
    checkOutput("we_t2", {31'd0, o_pack_fifo_we}, 32'd1);
    checkOutput("pair_word", o_pack_fifo_data, 32'h0022_8011);
    tick(1);
    checkOutput("we_single", {31'd0, o_pack_fifo_we}, 32'd0);

    // Trailing odd sample flushed after the timeout once record is low.
    doReset();
    startRecord();
    applyStimulus(16'h0001);
    applyStimulus(16'h0002);
    applyStimulus(16'h0003);
    i_record = 1'b0;
    waitWrites(2, 200);
    checkOutput("odd_cnt", 32'(wq.size() - wbase), 32'd2);
    if (wq.size() - wbase >= 2) begin
      checkOutput("odd_w0", wq[wbase], 32'h0002_8001);
      checkOutput("odd_w1", wq[wbase+1], 32'h4000_4003);
    end
    checkOutput("odd_idle", {31'd0, o_busy}, 32'd0);

    // Back-pressure: 6 words offered, 4 queued, 2 dropped with seq gap.
    doReset();
    startRecord();
    i_pack_fifo_full = 1'b1;
    for (int i = 1; i <= 12; i++) applyStimulus(16'(i));
    tick(3);
    checkOutput("bp_drop", {16'd0, o_drop_count}, 32'd4);
    checkOutput("bp_nowr", 32'(wq.size() - wbase), 32'd0);
    i_pack_fifo_full = 1'b0;
    waitWrites(4, 20);
    checkOutput("bp_cnt", 32'(wq.size() - wbase), 32'd4);
    if (wq.size() - wbase >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("bp_w%0d", i), wq[wbase+i],
                    mkWord(2'(i), 14'(2*i+2), (i == 0), 1'b0, 14'(2*i+1)));
        checkOutput($sformatf("bp_t%0d", i), 32'(wstamp[wbase+i] - wstamp[wbase]), 32'(i));
      end
    end
    wbase = wq.size();
    applyStimulus(16'd13);
    applyStimulus(16'd14);
    waitWrites(1, 20);
    checkOutput("gap_cnt", 32'(wq.size() - wbase), 32'd1);
    if (wq.size() - wbase >= 1)
      checkOutput("gap_word", wq[wbase], 32'h800E_000D);

    // Saturation of the drop counter and clear coincident with an odd drop.
    i_drop_clr = 1'b1;
    tick(1);
    i_drop_clr = 1'b0;
    checkOutput("clr_idle", {16'd0, o_drop_count}, 32'd0);
    i_pack_fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(16'(i));
    for (int i = 0; i < 65534; i++) applyStimulus(16'(i));
    tick(1);
    checkOutput("sat_fffe", {16'd0, o_drop_count}, 32'h0000_FFFE);
    applyStimulus(16'h0100);
    applyStimulus(16'h0200);
    tick(1);
    checkOutput("sat_ffff", {16'd0, o_drop_count}, 32'h0000_FFFF);
    applyStimulus(16'h0300);
    applyStimulus(16'h0400);
    tick(1);
    checkOutput("sat_hold", {16'd0, o_drop_count}, 32'h0000_FFFF);
    i_record = 1'b0;
    tick(5);
    i_drop_clr = 1'b1;
    tick(1);
    applyStimulus(16'h0055);
    for (int k = 0; k < 100; k++) begin
      if (o_drop_count == 16'd1) break;
      tick(1);
    end
    i_drop_clr = 1'b0;
    tick(2);
    checkOutput("clr_odd", {16'd0, o_drop_count}, 32'd1);

`ifdef ADC_PACK_DECIM_EN
    // Keep one of every three samples.
    doReset();
    i_decim = 4'd2;
    startRecord();
    for (int i = 1; i <= 6; i++) applyStimulus(16'(i));
    waitWrites(1, 20);
    checkOutput("dec_cnt", 32'(wq.size() - wbase), 32'd1);
    if (wq.size() - wbase >= 1)
      checkOutput("dec_word", wq[wbase], 32'h0004_8001);
    checkOutput("dec_busy", {31'd0, o_busy}, 32'd0);
`endif

    // Reset while holding a sample and draining queued words.
    doReset();
    startRecord();
    i_pack_fifo_full = 1'b1;
    for (int i = 1; i <= 5; i++) applyStimulus(16'(i));
    checkOutput("mid_busy", {31'd0, o_busy}, 32'd1);
    i_pack_fifo_full = 1'b0;
    tick(1);
    checkOutput("mid_we", {31'd0, o_pack_fifo_we}, 32'd1);
    checkOutput("mid_data", o_pack_fifo_data, 32'h0002_8001);
    i_rst_n = 1'b0;
    #1;
    checkOutput("async_we", {31'd0, o_pack_fifo_we}, 32'd0);
    checkOutput("async_data", o_pack_fifo_data, 32'h0);
    checkOutput("async_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("async_drop", {16'd0, o_drop_count}, 32'd0);
    tick(2);
    wbase = wq.size();
    i_rst_n = 1'b1;
    tick(20);
    checkOutput("post_rst_wr", 32'(wq.size() - wbase), 32'd0);
    checkOutput("post_rst_busy", {31'd0, o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Downstream consumer of one flash bus's ADC sample stream (the 16-bit sample-FIFO write port of the ADC master). Packs pairs of 14-bit samples into tagged 32-bit words and buffers them in a small queue. Drains the queue into a 32-bit pack FIFO read by the host. One instance per flash bus; drops on back-pressure are counted, never stall the ADC master.

## Interface
Parameters:
- QUEUE_DEPTH, 4, word-queue entries; power of two, ≥2
- FLUSH_TIMEOUT, 40, cycles to wait for a trailing sample after record ends (> one 34-cycle conversion)

Ports:
- i_clk  in  1  ADC clock; one clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_sample_data  in  16  sample; bits [13:0] used, [15:14] ignored
- i_sample_we  in  1  one-cycle sample strobe
- i_record  in  1  flash-bus record level, asynchronous; synchronized internally (2 flops)
- i_decim  in  4  keep 1 of (i_decim+1) samples; used only with ADC_PACK_DECIM_EN
- i_drop_clr  in  1  one-cycle clear of o_drop_count
- o_pack_fifo_data  out  32  packed word
- o_pack_fifo_we  out  1  one-cycle write strobe
- i_pack_fifo_full  in  1  pack FIFO full
- o_drop_count  out  16  saturating count of dropped samples
- o_busy  out  1  high when state is HALF or queue non-empty

## Operation
- Word format: [31:30] seq (mod 4, +1 per pushed word); [29:16] newer sample; [15] start-of-record; [14] odd (only [13:0] valid, [29:16]=0); [13:0] older sample.
- States: EMPTY (no held sample), HALF (one sample held).
  - EMPTY + accepted sample -> hold it, HALF.
  - HALF + accepted sample -> push full word, EMPTY.
  - HALF, synced record low, timer reaches FLUSH_TIMEOUT with no sample -> push odd word, EMPTY.
- Flush timer: cleared on entering HALF and whenever synced record is high; counts only in HALF with record low.
- Samples are accepted regardless of record level. Trailing samples after record falls pair normally.
- Record rising edge (synced):
  - seq -> 0.
  - Start flag armed; set on the next pushed word, then cleared.
  - Decimation counter reset.
  - A held sample in HALF is pushed as an odd word in the same cycle.
- Queue push allowed when not full, or when full with a pop in the same cycle.
  - Refused push: word discarded; o_drop_count += 2 (full word) or += 1 (odd word); saturates at 16'hFFFF.
  - seq still advances on a refused push, so gaps are visible to the host.
- i_drop_clr together with a drop: count loads the drop amount.
- Pop: each cycle the queue is non-empty and i_pack_fifo_full is low, the head is registered to o_pack_fifo_data with o_pack_fifo_we=1.

## Timing
- Reset values: o_pack_fifo_data=0, o_pack_fifo_we=0, o_drop_count=0, o_busy=0; state EMPTY, queue empty, seq 0, start flag armed.
- Assertion of i_rst_n low mid-word or mid-drain discards everything immediately; no partial output.
- Latency:
  - Second sample strobe at cycle t -> queue push at t+1 edge.
  - o_pack_fifo_we high in cycle t+2 if not full.
- i_record to internal edge: 2 cycles.
- Back-to-back samples every cycle are supported; sustained rate is one word per 2 samples.
- Full is sampled in the pop cycle; a write is never issued in a cycle following a sampled full.

## Configuration
- ADC_PACK_DECIM_EN defined: decimation counter loads i_decim on each kept sample and decrements on skipped ones. A sample is kept when the counter is 0. i_decim is sampled at each reload.
- Not defined: every sample is kept; i_decim is ignored and no counter is synthesized.

## Structure
- Shared package adc_pkg:
  - state encodings
  - word field bit positions (SEQ, NEW, START, ODD, OLD)
  - default FLUSH_TIMEOUT
- Sub-module adc_pack_queue: QUEUE_DEPTH×32 synchronous FIFO with push/pop/full/empty and simultaneous push-pop when full.

## Test plan
- Record high; samples 0x0011, 0x0022 -> one word 32'h0022_8011 (seq 0, start=1), o_pack_fifo_we 2 cycles after the second strobe.
- Three samples 0x0001/0x0002/0x0003, record drops, no more samples -> word 32'h0002_8001, then after FLUSH_TIMEOUT an odd word 32'h4000_4003 (seq 1).
- Hold i_pack_fifo_full, feed 12 samples with QUEUE_DEPTH=4 -> 4 words queued, o_drop_count=4; release full -> 4 writes on consecutive cycles, seq 0,1,2,3; the dropped words' seq values are skipped.
- Drop count at 16'hFFFE plus one dropped full word -> 16'hFFFF; i_drop_clr coincident with an odd-word drop -> 1.
- With ADC_PACK_DECIM_EN and i_decim=2, 6 samples 1..6 -> one word carrying samples 1 and 4.
- Reset asserted in HALF with 2 words queued -> all outputs 0 at once; no writes after release until new samples arrive.
